// File: rtl/rf_scan_pkg.sv
// Shared definitions for the rf_scan_master serial register-file scan driver.
package rf_scan_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 5;
    localparam int CHAIN_LEN    = DEF_DATA_W + DEF_ADDR_W;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STROBE,
        SYNC,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/rf_scan_sync.sv
// Two-flop synchronizer for the scan_sdo readback line; reset clears both stages.
module rf_scan_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rf_scan_master.sv
// Host-side driver for the 3-wire register-file scan port (valid/ready requests to serial scan).
// Define RF_SCAN_SDO_SYNC_EN to pass scan_sdo through a 2-flop synchronizer (adds 2 read cycles).
module rf_scan_master
    import rf_scan_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              scan_sdi,
    output logic              scan_load,
    output logic              scan_store,
    input  logic              scan_sdo
);

    localparam int CHAIN_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(CHAIN_W + 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 is_write, is_write_next;
    logic [CHAIN_W-1:0]   sr, sr_next;
    logic [CHAIN_W-1:0]   req_chain;
    logic                 sdo_s;

    logic                 req_ready_next;
    logic                 rsp_valid_next;
    logic                 rsp_err_next;
    logic [DATA_W-1:0]    rsp_rdata_next;
    logic                 scan_sdi_next;
    logic                 scan_load_next;
    logic                 scan_store_next;

`ifdef RF_SCAN_SDO_SYNC_EN
    localparam bit SYNC_EN = 1'b1;

    rf_scan_sync u_sdo_sync (
        .clk (clk),
        .rst (rst),
        .d   (scan_sdo),
        .q   (sdo_s)
    );
`else
    localparam bit SYNC_EN = 1'b0;

    assign sdo_s = scan_sdo;
`endif

    // Reads shift zeros into the data field so the target never sees stale write data.
    assign req_chain = {req_wdata & {DATA_W{req_write}}, req_addr};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_next      = state;
        cnt_next        = cnt;
        is_write_next   = is_write;
        sr_next         = sr;
        req_ready_next  = 1'b0;
        rsp_valid_next  = rsp_valid;
        rsp_err_next    = rsp_err;
        rsp_rdata_next  = rsp_rdata;
        scan_sdi_next   = 1'b0;
        scan_load_next  = 1'b0;
        scan_store_next = 1'b0;

        case (state)
            IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_next = 1'b0;
                    is_write_next  = req_write;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = '0;
                    if (32'(req_addr) >= NUM_REGS) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else begin
                        state_next    = SHIFT;
                        cnt_next      = CNT_W'(1);
                        scan_sdi_next = req_chain[CHAIN_W-1];
                        sr_next       = req_chain << 1;
                    end
                end
            end

            // cnt holds the index of the bit currently on scan_sdi.
            SHIFT: begin
                if (cnt == CNT_W'(CHAIN_W)) begin
                    state_next      = STROBE;
                    scan_store_next = is_write;
                    scan_load_next  = !is_write;
                end else begin
                    scan_sdi_next = sr[CHAIN_W-1];
                    sr_next       = sr << 1;
                    cnt_next      = cnt + 1'b1;
                end
            end

            STROBE: begin
                cnt_next = '0;
                if (is_write) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                end else begin
                    state_next = SYNC_EN ? SYNC : CAPTURE;
                end
            end

            SYNC: begin
                if (cnt == CNT_W'(SYNC_STAGES - 1)) begin
                    state_next = CAPTURE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            CAPTURE: begin
                rsp_rdata_next = {rsp_rdata[DATA_W-2:0], sdo_s};
                cnt_next       = cnt + 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = '0;
                    req_ready_next = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            scan_sdi   <= 1'b0;
            scan_load  <= 1'b0;
            scan_store <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            is_write   <= is_write_next;
            req_ready  <= req_ready_next;
            rsp_valid  <= rsp_valid_next;
            rsp_err    <= rsp_err_next;
            rsp_rdata  <= rsp_rdata_next;
            scan_sdi   <= scan_sdi_next;
            scan_load  <= scan_load_next;
            scan_store <= scan_store_next;
        end
    end

    // NOTE: the shift register is pure datapath, fully reloaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        sr <= sr_next;
    end

endmodule

// File: tb/tb_rf_scan_master.sv
// Directed self-checking bench for rf_scan_master with a behavioural 5x64 scan target model.
`timescale 1ns/1ps
module tb_rf_scan_master;

    localparam int CHAIN     = 69;
    localparam int STROBE_AT = 70;
    localparam int WRITE_RSP = 71;
`ifdef RF_SCAN_SDO_SYNC_EN
    localparam int READ_RSP  = 137;
`else
    localparam int READ_RSP  = 135;
`endif
    localparam logic [63:0] D1      = 64'hDEADBEEF_01234567;
    localparam logic [63:0] RF3_INIT = 64'h3333_2222_1111_0000;
    localparam logic [63:0] RF4_INIT = 64'hA5A5_0F0F_1234_8765;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        scan_sdi;
    logic        scan_load;
    logic        scan_store;
    logic        scan_sdo;

    always #5 clk = ~clk;

    rf_scan_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .scan_sdi   (scan_sdi),
        .scan_load  (scan_load),
        .scan_store (scan_store),
        .scan_sdo   (scan_sdo)
    );

    // Scan target: load > store > shift {data,addr} left with sdi into bit 0.
    logic [63:0] rf [5];
    logic [63:0] t_data = '0;
    logic [4:0]  t_addr = '0;

    assign scan_sdo = t_data[63];

    always @(posedge clk) begin
        if (scan_load) begin
            if (t_addr < 5'd5) t_data <= rf[t_addr[2:0]];
        end else if (scan_store) begin
            if (t_addr < 5'd5) rf[t_addr[2:0]] <= t_data;
        end else begin
            {t_data, t_addr} <= {t_data[62:0], t_addr, scan_sdi};
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Results of the last do_op call.
    logic [CHAIN-1:0] mon_sdi;
    int mon_load, mon_store, mon_strobe_cyc, mon_rsp_cyc;
    int mon_sdi_extra, mon_ready_hi, mon_accept_wait;

    task automatic do_op(input logic wr, input logic [4:0] addr, input logic [63:0] wdata);
        mon_sdi         = '0;
        mon_load        = 0;
        mon_store       = 0;
        mon_strobe_cyc  = -1;
        mon_rsp_cyc     = -1;
        mon_sdi_extra   = 0;
        mon_ready_hi    = 0;
        mon_accept_wait = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && mon_accept_wait < 50) begin
            @(negedge clk);
            mon_accept_wait++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc <= CHAIN) mon_sdi = {mon_sdi[CHAIN-2:0], scan_sdi};
            else if (scan_sdi) mon_sdi_extra++;
            if (scan_load) begin
                mon_load++;
                if (mon_strobe_cyc < 0) mon_strobe_cyc = cyc;
            end
            if (scan_store) begin
                mon_store++;
                if (mon_strobe_cyc < 0) mon_strobe_cyc = cyc;
            end
            if (req_ready) mon_ready_hi++;
            if (rsp_valid) begin
                mon_rsp_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unstable;
        int pulses;
        for (int i = 0; i < 5; i++) rf[i] = '0;
        rf[3] = RF3_INIT;
        rf[4] = RF4_INIT;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 128'({req_ready, rsp_valid, rsp_err, scan_sdi, scan_load, scan_store}), 128'(0));
        check("reset_rdata", 128'(rsp_rdata), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(req_ready), 128'(1));

        // 1: write addr 2
        do_op(1'b1, 5'd2, D1);
        check("t1_chain", 128'(mon_sdi), 128'({D1, 5'd2}));
        check("t1_store_cycle", 128'(mon_strobe_cyc), 128'(STROBE_AT));
        check("t1_pulses", 128'({mon_store[7:0], mon_load[7:0]}), 128'(16'h0100));
        check("t1_rsp_cycle", 128'(mon_rsp_cyc), 128'(WRITE_RSP));
        check("t1_rsp", 128'({rsp_err, rsp_rdata}), 128'(0));
        check("t1_busy", 128'(mon_ready_hi + mon_sdi_extra), 128'(0));
        check("t1_model_rf2", 128'(rf[2]), 128'(D1));
        handshake();

        // 2 / 6: read addr 2 (junk wdata must not reach the chain)
        do_op(1'b0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_chain", 128'(mon_sdi), 128'({64'h0, 5'd2}));
        check("t2_load_cycle", 128'(mon_strobe_cyc), 128'(STROBE_AT));
        check("t2_pulses", 128'({mon_store[7:0], mon_load[7:0]}), 128'(16'h0001));
        check("t2_rsp_cycle", 128'(mon_rsp_cyc), 128'(READ_RSP));
        check("t2_rdata", 128'(rsp_rdata), 128'(D1));
        check("t2_err", 128'(rsp_err), 128'(0));
        handshake();

        // 3: out-of-range read
        do_op(1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_rsp_cycle", 128'(mon_rsp_cyc), 128'(1));
        check("t3_rsp", 128'({rsp_err, rsp_rdata}), 128'({1'b1, 64'h0}));
        check("t3_no_scan", 128'(mon_load + mon_store + mon_sdi_extra + int'(mon_sdi != '0)), 128'(0));
        handshake();

        // 4: read addr 4 with response back-pressure
        do_op(1'b0, 5'd4, 64'h0);
        check("t4_rsp_cycle", 128'(mon_rsp_cyc), 128'(READ_RSP));
        check("t4_rdata", 128'(rsp_rdata), 128'(RF4_INIT));
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== RF4_INIT || req_ready !== 1'b0)
                unstable++;
        end
        check("t4_hold_stable", 128'(unstable), 128'(0));
        handshake();
        do_op(1'b1, 5'd4, 64'h0123_4567_89AB_CDEF);
        check("t4_next_accept_wait", 128'(mon_accept_wait), 128'(0));
        check("t4_next_rsp_cycle", 128'(mon_rsp_cyc), 128'(WRITE_RSP));
        check("t4_model_rf4", 128'(rf[4]), 128'(64'h0123_4567_89AB_CDEF));
        handshake();

        // 5: reset in the middle of a write to addr 3
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd3;
        req_wdata = 64'hFEED_FACE_CAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_ctrl_after_rst", 128'({req_ready, rsp_valid, rsp_err, scan_sdi, scan_load, scan_store}), 128'(0));
        check("t5_rdata_after_rst", 128'(rsp_rdata), 128'(0));
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scan_load || scan_store) pulses++;
        end
        check("t5_no_strobe", 128'(pulses), 128'(0));
        check("t5_model_rf3_kept", 128'(rf[3]), 128'(RF3_INIT));
        do_op(1'b1, 5'd3, 64'hFEED_FACE_CAFE_F00D);
        check("t5_retry_rsp_cycle", 128'(mon_rsp_cyc), 128'(WRITE_RSP));
        check("t5_retry_store", 128'(mon_store), 128'(1));
        check("t5_model_rf3_new", 128'(rf[3]), 128'(64'hFEED_FACE_CAFE_F00D));
        handshake();

        do_op(1'b0, 5'd3, 64'h0);
        check("t5_readback", 128'(rsp_rdata), 128'(64'hFEED_FACE_CAFE_F00D));
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
